// File: rtl/sram_req_bridge.sv
// sram_req_bridge
//   Initiator side of the core-facing SRAM port. Takes one byte-addressed
//   load/store at a time, turns it into a single-cycle io_sram_en strobe with
//   word address, lane-replicated store data and byte mask, captures read
//   data one cycle after issue, aligns/extends it, and returns it on a
//   valid/ready response channel.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_addr,        store flag, byte address, size (0 byte, 1 half,
//   req_size, req_signed,    2 word, 3 reserved), sign-extend loads,
//   req_wdata                right-justified store data
//   resp_valid/resp_ready    response handshake
//   resp_rdata, resp_err     aligned load data (0 for stores/errors), error
//   io_sram_en/we/addr/      SRAM strobe, write enable, word address,
//   din/wmask                replicated data, byte-lane mask
//   io_sram_dout             read word, valid the cycle after the en cycle
module sram_req_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int          AW        = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          io_sram_en,
    output logic          io_sram_we,
    output logic [AW-1:0] io_sram_addr,
    output logic [31:0]   io_sram_din,
    output logic [3:0]    io_sram_wmask,
    input  logic [31:0]   io_sram_dout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state;
    logic       lat_we;
    logic       lat_signed;
    logic [1:0] lat_size;
    logic [1:0] lat_off;

    logic        acc_err;
    logic [3:0]  acc_mask;
    logic [31:0] acc_din;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    // Acceptance-time decode: legality, store mask and replicated data.
    always_comb begin
        acc_err  = 1'b0;
        acc_mask = 4'b1111;
        acc_din  = req_wdata;
        case (req_size)
            2'd0: begin
                acc_mask = 4'b0001 << req_addr[1:0];
                acc_din  = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                acc_err  = req_addr[0];
                acc_mask = 4'b0011 << req_addr[1:0];
                acc_din  = {2{req_wdata[15:0]}};
            end
            2'd2: acc_err = (req_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
        if (req_addr[31:AW+2] != ADDR_BASE[31:AW+2])
            acc_err = 1'b1;
        // Loads read the whole word; lane selection happens on return.
        if (!req_we)
            acc_mask = 4'b1111;
    end

    // Read-return alignment: move the addressed lane to bit 0, then extend.
    always_comb begin
        shifted = io_sram_dout >> {lat_off, 3'b000};
        case (lat_size)
            2'd0:    ld_data = {{24{lat_signed & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_data = {{16{lat_signed & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_rdata    <= '0;
            io_sram_en    <= 1'b0;
            io_sram_we    <= 1'b0;
            io_sram_addr  <= '0;
            io_sram_din   <= '0;
            io_sram_wmask <= '0;
            lat_we        <= 1'b0;
            lat_signed    <= 1'b0;
            lat_size      <= '0;
            lat_off       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        lat_we     <= req_we;
                        lat_signed <= req_signed;
                        lat_size   <= req_size;
                        lat_off    <= req_addr[1:0];
                        if (acc_err) begin
                            // Illegal requests never touch the SRAM.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state         <= ISSUE;
                            io_sram_en    <= 1'b1;
                            io_sram_we    <= req_we;
                            io_sram_addr  <= req_addr[AW+1:2];
                            io_sram_din   <= acc_din;
                            io_sram_wmask <= acc_mask;
                        end
                    end
                end
                ISSUE: begin
                    // Strobe lasts exactly this one cycle.
                    io_sram_en <= 1'b0;
                    io_sram_we <= 1'b0;
                    if (lat_we) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= ld_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
